// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and helpers for the instruction fetch unit
package fetch_pkg;

    // Fetch sequencer states: wait one cycle after reset, request a word, hold it for the consumer
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] WORD_MASK        = 32'(WORD_BYTES - 1);
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Force an address onto a word boundary
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~WORD_MASK;
    endfunction

    // True when an address has any byte-offset bits set
    function automatic logic is_misaligned(input logic [31:0] addr);
        return |(addr & WORD_MASK);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - 32-bit loadable program counter register with async active-low reset
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    // Hold the PC; take a new value only when the fetch unit retires an instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RESET_PC;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch unit with retire handshake
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    // Starting retire count; lets a resumed context continue its count instead of restarting at zero
    parameter logic [31:0] RESET_RETIRED = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        err_misaligned,
    output logic [31:0] retired_count
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic         w_imem_req;
    logic         w_ack_take;
    logic         w_retire;
    logic [31:0]  w_pc;
    logic [31:0]  w_pc_load;
    logic [31:0]  r_instr;
    logic         r_instr_valid;
    logic         r_err_misaligned;
    logic [31:0]  r_retired_count;

    // An ack only counts while a request is out; a retire only counts while an instruction is held.
    // Because these are mutually exclusive by state, a ready arriving with an ack in FETCH is dropped.
    assign w_ack_take = (r_state == ST_FETCH) && imem_ack;
    assign w_retire   = (r_state == ST_HOLD) && instr_ready;
    assign w_pc_load  = align_pc(next_pc);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_retire),
        .i_d    (w_pc_load),
        .o_q    (w_pc)
    );

    // State register; async reset returns to BOOT so the request drops without a clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and request decode
    always_comb begin
        w_state_next = r_state;
        w_imem_req   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // Capture the fetched word on ack; it stays put until the next ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr <= 32'h0000_0000;
        end else if (w_ack_take) begin
            r_instr <= imem_rdata;
        end
    end

    // Valid rises the cycle after the ack and falls on the retire edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_valid <= 1'b0;
        end else if (w_ack_take) begin
            r_instr_valid <= 1'b1;
        end else if (w_retire) begin
            r_instr_valid <= 1'b0;
        end
    end

    // Sticky misalignment flag; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_misaligned <= 1'b0;
        end else if (w_retire && is_misaligned(next_pc)) begin
            r_err_misaligned <= 1'b1;
        end
    end

    // Retired instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retired_count <= RESET_RETIRED;
        end else if (w_retire) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    assign pc             = w_pc;
    assign imem_addr      = w_pc;
    assign imem_req       = w_imem_req;
    assign instr          = r_instr;
    assign instr_valid    = r_instr_valid;
    assign err_misaligned = r_err_misaligned;
    assign retired_count  = r_retired_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit with directed and random phases
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        err_misaligned;
    logic [31:0] retired_count;

    // second instance: nonzero reset PC and a retire count one below wrap
    logic        u2_rst;
    logic [31:0] u2_next_pc;
    logic [31:0] u2_pc;
    logic        u2_imem_req;
    logic [31:0] u2_imem_addr;
    logic        u2_imem_ack;
    logic [31:0] u2_imem_rdata;
    logic [31:0] u2_instr;
    logic        u2_instr_valid;
    logic        u2_instr_ready;
    logic        u2_err_misaligned;
    logic [31:0] u2_retired_count;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .pc             (pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .err_misaligned (err_misaligned),
        .retired_count  (retired_count)
    );

    fetch_unit #(
        .RESET_PC      (32'h0000_1000),
        .RESET_RETIRED (32'hFFFF_FFFF)
    ) dut_wrap (
        .clk            (clk),
        .rst            (u2_rst),
        .next_pc        (u2_next_pc),
        .pc             (u2_pc),
        .imem_req       (u2_imem_req),
        .imem_addr      (u2_imem_addr),
        .imem_ack       (u2_imem_ack),
        .imem_rdata     (u2_imem_rdata),
        .instr          (u2_instr),
        .instr_valid    (u2_instr_valid),
        .instr_ready    (u2_instr_ready),
        .err_misaligned (u2_err_misaligned),
        .retired_count  (u2_retired_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string why);
        n_checks++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // scoreboard queues filled by the reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        err;
    } retire_t;

    logic [31:0] exp_instr[$];
    retire_t     exp_retire[$];
    logic        mon_en = 1'b0;

    // monitor: pops expectations whenever the DUT presents a fetched word or completes a retire
    logic        prev_ack_fetch = 1'b0;
    logic        prev_retire    = 1'b0;
    logic [31:0] cur_pc         = 32'h0;
    logic [31:0] cur_cnt        = 32'h0;
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_ack_fetch = 1'b0;
            prev_retire    = 1'b0;
            cur_pc         = 32'h0;
            cur_cnt        = 32'h0;
        end else begin
            if (prev_ack_fetch) begin
                if (exp_instr.size() == 0) begin
                    fail_now("sb_instr", "DUT accepted an ack the model did not expect");
                end else begin
                    check("sb_instr_data", instr, exp_instr.pop_front());
                    check("sb_instr_valid", {31'b0, instr_valid}, 32'd1);
                end
            end
            if (prev_retire) begin
                if (exp_retire.size() == 0) begin
                    fail_now("sb_retire", "DUT retired without a model retire");
                end else begin
                    retire_t r;
                    r = exp_retire.pop_front();
                    check("sb_pc", pc, r.pc);
                    check("sb_count", retired_count, r.cnt);
                    check("sb_err", {31'b0, err_misaligned}, {31'b0, r.err});
                    check("sb_valid_drop", {31'b0, instr_valid}, 32'd0);
                    cur_pc  = r.pc;
                    cur_cnt = r.cnt;
                end
            end
            if (imem_req) begin
                check("sb_imem_addr", imem_addr, cur_pc);
                check("sb_count_stable", retired_count, cur_cnt);
            end
            prev_ack_fetch = imem_req && imem_ack;
            prev_retire    = instr_valid && instr_ready;
        end
    end

    logic        m_warm;
    logic        m_have;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;
    int unsigned sel;

    initial begin
        rst = 1'b0; next_pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        u2_rst = 1'b0; u2_next_pc = 32'h0; u2_imem_ack = 1'b0; u2_imem_rdata = 32'h0; u2_instr_ready = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_err", {31'b0, err_misaligned}, 32'd0);
        check("rst_count", retired_count, 32'd0);

        // first fetch with immediate ack
        tick(); rst = 1'b1;
        @(negedge clk);
        check("boot_req", {31'b0, imem_req}, 32'd0);
        tick(); imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("fetch0_req", {31'b0, imem_req}, 32'd1);
        check("fetch0_addr", imem_addr, 32'h0);
        check("fetch0_valid", {31'b0, instr_valid}, 32'd0);
        tick(); imem_ack = 1'b0;
        @(negedge clk);
        check("hold0_instr", instr, 32'h1234_5678);
        check("hold0_valid", {31'b0, instr_valid}, 32'd1);
        check("hold0_req", {31'b0, imem_req}, 32'd0);
        tick(); instr_ready = 1'b1; next_pc = 32'h0000_0040;
        @(negedge clk);
        check("hold0_instr_stable", instr, 32'h1234_5678);
        tick(); instr_ready = 1'b0;
        @(negedge clk);
        check("ret1_pc", pc, 32'h40);
        check("ret1_count", retired_count, 32'd1);
        check("ret1_req", {31'b0, imem_req}, 32'd1);
        check("ret1_valid", {31'b0, instr_valid}, 32'd0);

        // ack withheld, ready pulses in FETCH must be ignored
        for (int i = 0; i < 5; i++) begin
            tick(); instr_ready = (i % 2 == 0); next_pc = 32'h0000_0080;
            @(negedge clk);
            check("stall_req", {31'b0, imem_req}, 32'd1);
            check("stall_addr", imem_addr, 32'h40);
            check("stall_pc", pc, 32'h40);
            check("stall_count", retired_count, 32'd1);
        end

        // ack and ready together in FETCH: only the ack lands
        tick(); imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        tick(); imem_ack = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        check("both_pc", pc, 32'h40);
        check("both_count", retired_count, 32'd1);
        check("both_valid", {31'b0, instr_valid}, 32'd1);
        check("both_instr", instr, 32'hAAAA_5555);

        // misaligned retire
        tick(); instr_ready = 1'b1; next_pc = 32'h0000_0043;
        @(negedge clk);
        tick(); instr_ready = 1'b0;
        @(negedge clk);
        check("mis_pc", pc, 32'h40);
        check("mis_err", {31'b0, err_misaligned}, 32'd1);
        check("mis_count", retired_count, 32'd2);

        // sticky across three more aligned retires
        for (int i = 0; i < 3; i++) begin
            tick(); imem_ack = 1'b1; imem_rdata = 32'(i);
            @(negedge clk);
            tick(); imem_ack = 1'b0; instr_ready = 1'b1; next_pc = 32'h100 + 32'(16 * i);
            @(negedge clk);
            tick(); instr_ready = 1'b0;
            @(negedge clk);
            check("sticky_err", {31'b0, err_misaligned}, 32'd1);
            check("sticky_pc", pc, 32'h100 + 32'(16 * i));
            check("sticky_count", retired_count, 32'(3 + i));
        end

        // reset mid-fetch drops the request without a clock; late ack after release is ignored
        tick();
        @(negedge clk);
        check("mid_req_before", {31'b0, imem_req}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async_req", {31'b0, imem_req}, 32'd0);
        check("async_pc", pc, 32'h0);
        check("async_err", {31'b0, err_misaligned}, 32'd0);
        check("async_count", retired_count, 32'd0);
        tick();
        tick(); rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("late_boot_req", {31'b0, imem_req}, 32'd0);
        tick(); imem_ack = 1'b0;
        @(negedge clk);
        check("late_fetch_req", {31'b0, imem_req}, 32'd1);
        check("late_valid", {31'b0, instr_valid}, 32'd0);
        check("late_instr", instr, 32'h0);

        // wrap instance: counter and PC wrap
        @(negedge clk);
        check("wrap_rst_pc", u2_pc, 32'h0000_1000);
        tick(); u2_rst = 1'b1;
        tick(); u2_imem_ack = 1'b1; u2_imem_rdata = 32'h0000_0001;
        @(negedge clk);
        check("wrap_fetch_addr", u2_imem_addr, 32'h0000_1000);
        tick(); u2_imem_ack = 1'b0; u2_instr_ready = 1'b1; u2_next_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_count_pre", u2_retired_count, 32'hFFFF_FFFF);
        tick(); u2_instr_ready = 1'b0;
        @(negedge clk);
        check("wrap_count", u2_retired_count, 32'h0);
        check("wrap_pc", u2_pc, 32'hFFFF_FFFC);
        check("wrap_err", {31'b0, u2_err_misaligned}, 32'd0);

        // randomized phase against the transaction-level model
        tick(); rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        exp_instr.delete(); exp_retire.delete();
        m_warm = 1'b0; m_have = 1'b0; m_pc = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
        tick();
        tick(); rst = 1'b1; mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            imem_ack    = ($urandom_range(0, 2) == 0);
            imem_rdata  = $urandom;
            instr_ready = ($urandom_range(0, 1) == 1);
            sel         = $urandom_range(0, 31);
            if (sel == 0)      next_pc = 32'hFFFF_FFFC;
            else if (sel == 1) next_pc = $urandom;
            else               next_pc = $urandom & 32'hFFFF_FFFC;
            if (!m_warm) begin
                m_warm = 1'b1;
            end else if (!m_have) begin
                if (imem_ack) begin
                    exp_instr.push_back(imem_rdata);
                    m_have = 1'b1;
                end
            end else if (instr_ready) begin
                m_pc  = next_pc - (next_pc % 4);
                m_cnt = m_cnt + 1;
                m_err = m_err | ((next_pc % 4) != 0);
                exp_retire.push_back('{m_pc, m_cnt, m_err});
                m_have = 1'b0;
            end
            tick();
        end
        imem_ack = 1'b0; instr_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        mon_en = 1'b0;
        check("drain_instr", 32'(exp_instr.size()), 32'd0);
        check("drain_retire", 32'(exp_retire.size()), 32'd0);
        check("final_count", retired_count, m_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
